// File: rtl/counter_pkg.sv
// ============================================================================
//  Module   : counter_pkg
//  Brief    : Shared encodings and widths for the periodic counter block.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package counter_pkg;

    localparam int DELAY_W = 10;

    localparam logic [2:0] UNIT_CYC = 3'b000;
    localparam logic [2:0] UNIT_US  = 3'b001;
    localparam logic [2:0] UNIT_MS  = 3'b010;
    localparam logic [2:0] UNIT_S   = 3'b011;

    // A zero-length period is treated as a one-unit period.
    function automatic logic [DELAY_W-1:0] eff_target(input logic [DELAY_W-1:0] t);
        return (t == '0) ? {{(DELAY_W-1){1'b0}}, 1'b1} : t;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tick_gen.sv
// ============================================================================
//  Module   : tick_gen
//  Brief    : Prescaler; pulses tick once every div clock cycles.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] div,
    output logic        tick
);

    logic [31:0] r_p;

    assign tick = (r_p == div - 32'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_p <= '0;
        end else begin
            r_p <= tick ? 32'd0 : r_p + 32'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/counter.sv
// ============================================================================
//  Module   : counter
//  Brief    : Free-running periodic timer with selectable time base.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter
    import counter_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DELAY_W-1:0] delay,
    input  logic [2:0]         delay_unit,
    input  logic [DELAY_W-1:0] manual_delay,
    input  logic               debug_flag,
    output logic               count_done
);

    localparam logic [31:0] C_DIV_US = (CLK_FREQ_HZ / 1_000_000 == 0) ? 32'd1
                                                                     : 32'(CLK_FREQ_HZ / 1_000_000);
    localparam logic [31:0] C_DIV_MS = (CLK_FREQ_HZ / 1_000 == 0) ? 32'd1
                                                                 : 32'(CLK_FREQ_HZ / 1_000);
    localparam logic [31:0] C_DIV_S  = (CLK_FREQ_HZ == 0) ? 32'd1 : 32'(CLK_FREQ_HZ);
    localparam logic [DELAY_W-1:0] C_ONE = {{(DELAY_W-1){1'b0}}, 1'b1};

    logic [DELAY_W-1:0] r_cnt;
    logic [DELAY_W-1:0] r_n;
    logic [31:0]        r_div;
    logic               r_done;
    logic               r_start;

    logic [31:0]        w_new_div;
    logic [DELAY_W-1:0] w_new_n;
    logic [31:0]        w_div;
    logic [DELAY_W-1:0] w_n;
    logic               w_tick;
    logic               w_wrap;

    always_comb begin
        w_new_div = 32'd1;
        if (!debug_flag) begin
            case (delay_unit)
                UNIT_US: w_new_div = C_DIV_US;
                UNIT_MS: w_new_div = C_DIV_MS;
                UNIT_S:  w_new_div = C_DIV_S;
                default: w_new_div = 32'd1;
            endcase
        end
        w_new_n = eff_target(debug_flag ? manual_delay : delay);
    end

    // r_start marks the first cycle of a period (counter and prescaler both
    // at zero); the live inputs are used in that cycle and latched for the rest.
    assign w_div  = r_start ? w_new_div : r_div;
    assign w_n    = r_start ? w_new_n   : r_n;
    assign w_wrap = w_tick && (r_cnt == w_n - C_ONE);

    tick_gen u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .div  (w_div),
        .tick (w_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_n     <= '0;
            r_div   <= '0;
            r_done  <= 1'b0;
            r_start <= 1'b1;
        end else begin
            if (r_start) begin
                r_div <= w_new_div;
                r_n   <= w_new_n;
            end
            if (w_tick) begin
                r_cnt <= w_wrap ? '0 : r_cnt + C_ONE;
            end
            r_done  <= w_wrap;
            r_start <= w_wrap;
        end
    end

    assign count_done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_counter.sv
// ============================================================================
//  Module   : tb_counter
//  Brief    : Self-checking bench for counter using a pulse-edge scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_counter;

    logic       clk;
    logic       rst;
    logic [9:0] delay;
    logic [2:0] delay_unit;
    logic [9:0] manual_delay;
    logic       debug_flag;
    logic       count_done;

    int errors = 0;
    int checks = 0;
    int edge_n = 0;
    int sb[$];

    counter #(.CLK_FREQ_HZ(100_000_000)) dut (
        .clk          (clk),
        .rst          (rst),
        .delay        (delay),
        .delay_unit   (delay_unit),
        .manual_delay (manual_delay),
        .debug_flag   (debug_flag),
        .count_done   (count_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hold reset for two edges, then release; edges are counted from release.
    task automatic apply_reset();
        rst = 1'b0;
        #1;
        checks++;
        if (count_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: count_done=%b expected 0", count_done);
        end
        repeat (2) begin
            @(posedge clk); #1;
            checks++;
            if (count_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: count_done=%b expected 0", count_done);
            end
        end
        rst    = 1'b1;
        edge_n = 0;
        sb.delete();
    endtask

    task automatic push_every(input int period, input int count, input int first);
        for (int k = 0; k < count; k++) sb.push_back(first + k * period);
    endtask

    task automatic run_check(input int n, input string tag);
        logic exp_v;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            edge_n++;
            exp_v = (sb.size() > 0 && sb[0] == edge_n);
            if (exp_v) void'(sb.pop_front());
            checks++;
            if (count_done !== exp_v) begin
                errors++;
                $display("FAIL %s edge %0d: count_done=%b expected %b", tag, edge_n, count_done, exp_v);
            end
        end
    endtask

    task automatic drain_check(input string tag);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected pulses not seen, next at edge %0d", tag, sb.size(), sb[0]);
        end
    endtask

    task automatic set_cfg(input logic [9:0] d, input logic [2:0] u,
                           input logic [9:0] m, input logic dbg);
        delay        = d;
        delay_unit   = u;
        manual_delay = m;
        debug_flag   = dbg;
    endtask

    task automatic test_reset();
        set_cfg(10'd10, 3'b000, 10'd0, 1'b0);
        apply_reset();
    endtask

    task automatic test_basic();
        set_cfg(10'd10, 3'b000, 10'd0, 1'b0);
        apply_reset();
        push_every(10, 3, 10);
        run_check(35, "basic_d10");
        drain_check("basic_d10_drain");
    endtask

    task automatic test_zero_one();
        set_cfg(10'd0, 3'b000, 10'd0, 1'b0);
        apply_reset();
        push_every(1, 8, 1);
        run_check(8, "delay0");
        drain_check("delay0_drain");
        set_cfg(10'd1, 3'b000, 10'd0, 1'b0);
        apply_reset();
        push_every(1, 8, 1);
        run_check(8, "delay1");
        drain_check("delay1_drain");
        // count_done is high here, so the reset clears it asynchronously.
        apply_reset();
    endtask

    task automatic test_time_base();
        set_cfg(10'd3, 3'b001, 10'd0, 1'b0);
        apply_reset();
        push_every(300, 2, 300);
        run_check(610, "unit_us");
        drain_check("unit_us_drain");
        set_cfg(10'd4, 3'b101, 10'd0, 1'b0);
        apply_reset();
        push_every(4, 3, 4);
        run_check(12, "unit_reserved");
        drain_check("unit_reserved_drain");
    endtask

    task automatic test_debug();
        set_cfg(10'd100, 3'b010, 10'd5, 1'b1);
        apply_reset();
        push_every(5, 4, 5);
        run_check(22, "debug_m5");
        drain_check("debug_m5_drain");
    endtask

    task automatic test_mid_change();
        set_cfg(10'd10, 3'b000, 10'd0, 1'b0);
        apply_reset();
        sb.push_back(10);
        push_every(4, 3, 14);
        run_check(5, "midchg_pre");
        delay = 10'd4;
        run_check(19, "midchg_post");
        drain_check("midchg_drain");
    endtask

    task automatic test_reset_mid();
        set_cfg(10'd10, 3'b000, 10'd0, 1'b0);
        apply_reset();
        run_check(7, "rstmid_pre");
        apply_reset();
        push_every(10, 2, 10);
        run_check(22, "rstmid_post");
        drain_check("rstmid_drain");
    endtask

    initial begin
        rst = 1'b0;
        set_cfg(10'd0, 3'b000, 10'd0, 1'b0);
        test_reset();
        test_basic();
        test_zero_one();
        test_time_base();
        test_debug();
        test_mid_change();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
